// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and
// buffers fetched words in order so fetch can run ahead of a stalled decode.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               valid_q;
    logic               ce_q;
    logic [31:0]        pc;

    logic               pop_c;
    logic               push_c;
    logic               full_c;
    logic [CNT_W-1:0]   count_nxt;
    logic [31:0]        pc_nxt;
    logic               unused_redirect_lsb;

    // Word alignment drops the low target bits.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Handshake, occupancy and PC next-state; redirect wins over push/pop.
    always_comb begin
        pop_c     = valid_q & out_ready;
        full_c    = (count == CNT_W'(DEPTH));
        push_c    = ce_q & ~redirect & (~full_c | pop_c);
        count_nxt = count;
        pc_nxt    = pc;
        if (redirect) begin
            count_nxt = '0;
            pc_nxt    = {redirect_pc[31:2], 2'b00};
        end else begin
            if (push_c && !pop_c) begin
                count_nxt = count + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_nxt = count - CNT_W'(1);
            end
            if (push_c) begin
                pc_nxt = pc + 32'd4;
            end
        end
    end

    // PC, enable and buffer bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ce_q    <= 1'b0;
            count   <= '0;
            valid_q <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            pc      <= pc_nxt;
            ce_q    <= 1'b1;
            count   <= count_nxt;
            valid_q <= (count_nxt != '0);
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Buffer storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= {pc, rom_inst};
        end
    end

    assign rom_ce    = ce_q;
    assign rom_addr  = pc;
    assign out_valid = valid_q;
    assign out_pc    = mem[rd_ptr].pc;
    assign out_inst  = mem[rd_ptr].inst;

endmodule
